// File: rtl/ds_countdown.sv
// Loadable M:SS.d BCD countdown timer with a decisecond prescaler.
// Counts the loaded value down to 0:00.0 and then pulses expired for one cycle.
module ds_countdown #(
    parameter int TICK_DIV = 10000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        start,
    input  logic        pause,
    output logic [3:0]  min,
    output logic [3:0]  sec_t,
    output logic [3:0]  sec_o,
    output logic [3:0]  ds,
    output logic        running,
    output logic        done,
    output logic        expired
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE,
        ST_DONE
    } state_t;

    state_t          state_reg, state_next;
    logic [PW-1:0]   presc_reg, presc_next;
    logic [3:0]      dig_reg   [4];
    logic [3:0]      dig_next  [4];
    logic [3:0]      dig_clamp [4];
    logic [3:0]      dig_dec   [4];
    logic [3:0]      dig_zero;
    logic            expired_reg, expired_next;
    logic            val_zero;
    logic            val_one;
    logic            tick;

    // Digit index 0 = deciseconds ... 3 = minutes; only the seconds-tens digit tops out at 5.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            localparam logic [3:0] LIM      = (gi == 2) ? 4'd5 : 4'd9;
            localparam logic [3:0] LOW_MASK = 4'((1 << gi) - 1);

            assign dig_zero[gi]  = (dig_reg[gi] == 4'd0);
            assign dig_clamp[gi] = (load_val[gi*4 +: 4] > LIM) ? LIM : load_val[gi*4 +: 4];
            // A digit borrows when every less significant digit is zero.
            assign dig_dec[gi]   = ((dig_zero & LOW_MASK) != LOW_MASK) ? dig_reg[gi] :
                                   (dig_zero[gi] ? LIM : dig_reg[gi] - 4'd1);
        end
    endgenerate

    assign val_zero = &dig_zero;
    assign val_one  = (&dig_zero[3:1]) && (dig_reg[0] == 4'd1);
    assign tick     = (presc_reg == PRESC_MAX);

    always_comb begin
        state_next   = state_reg;
        presc_next   = presc_reg;
        dig_next     = dig_reg;
        expired_next = 1'b0;

        if (clear) begin
            state_next = ST_IDLE;
            presc_next = '0;
            for (int i = 0; i < 4; i++) dig_next[i] = 4'd0;
        end else if (load && state_reg != ST_RUN) begin
            state_next = ST_IDLE;
            presc_next = '0;
            dig_next   = dig_clamp;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (!pause && start && !val_zero) begin
                        state_next = ST_RUN;
                        presc_next = '0;
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        state_next = ST_PAUSE;
                    end else if (tick) begin
                        presc_next = '0;
                        if (!val_zero) dig_next = dig_dec;
                        if (val_one) begin
                            state_next   = ST_DONE;
                            expired_next = 1'b1;
                        end
                    end else begin
                        presc_next = presc_reg + 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (!pause && start) state_next = ST_RUN;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            presc_reg   <= '0;
            expired_reg <= 1'b0;
            for (int i = 0; i < 4; i++) dig_reg[i] <= 4'd0;
        end else begin
            state_reg   <= state_next;
            presc_reg   <= presc_next;
            expired_reg <= expired_next;
            dig_reg     <= dig_next;
        end
    end

    assign min     = dig_reg[3];
    assign sec_t   = dig_reg[2];
    assign sec_o   = dig_reg[1];
    assign ds      = dig_reg[0];
    assign running = (state_reg == ST_RUN);
    assign done    = (state_reg == ST_DONE);
    assign expired = expired_reg;

endmodule

// File: tb/tb_ds_countdown.sv
// Self-checking bench for ds_countdown: table vectors, directed corner sequences,
// and a randomized run against a decisecond-count reference model.
module tb_ds_countdown;

    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        load = 1'b0;
    logic [15:0] load_val = 16'h0;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic [3:0]  min, sec_t, sec_o, ds;
    logic        running, done, expired;
    logic [15:0] dut_val;

    int checks = 0;
    int errors = 0;

    ds_countdown #(.TICK_DIV(TD)) dut (
        .clk(clk), .rst(rst), .clear(clear), .load(load), .load_val(load_val),
        .start(start), .pause(pause), .min(min), .sec_t(sec_t), .sec_o(sec_o),
        .ds(ds), .running(running), .done(done), .expired(expired)
    );

    assign dut_val = {min, sec_t, sec_o, ds};

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] lv;
        bit          go;
        int          wait_n;
        logic [15:0] exp_val;
        bit          exp_run;
        bit          exp_done;
    } vec_t;

    vec_t vecs[8];

    // Reference model: the timer value as a plain count of deciseconds.
    int m_mode;   // 0 idle, 1 run, 2 pause, 3 done
    int m_val;
    int m_pre;
    bit m_exp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] to_bcd(input int d);
        int m, r;
        m = d / 600;
        r = d % 600;
        return {4'(m), 4'(r / 100), 4'((r % 100) / 10), 4'(r % 10)};
    endfunction

    function automatic int clamp_decis(input logic [15:0] lv);
        int m, st, so, d;
        m  = (lv[15:12] > 4'd9) ? 9 : int'(lv[15:12]);
        st = (lv[11:8]  > 4'd5) ? 5 : int'(lv[11:8]);
        so = (lv[7:4]   > 4'd9) ? 9 : int'(lv[7:4]);
        d  = (lv[3:0]   > 4'd9) ? 9 : int'(lv[3:0]);
        return m * 600 + st * 100 + so * 10 + d;
    endfunction

    task automatic model_step(input bit r, input bit c, input bit l, input logic [15:0] lv,
                              input bit s, input bit p);
        m_exp = 1'b0;
        if (r || c) begin
            m_mode = 0; m_val = 0; m_pre = 0;
        end else if (l && m_mode != 1) begin
            m_mode = 0; m_val = clamp_decis(lv); m_pre = 0;
        end else if (m_mode == 0) begin
            if (!p && s && m_val != 0) begin m_mode = 1; m_pre = 0; end
        end else if (m_mode == 1) begin
            if (p) m_mode = 2;
            else begin
                m_pre++;
                if (m_pre == TD) begin
                    m_pre = 0;
                    m_val--;
                    if (m_val == 0) begin m_mode = 3; m_exp = 1'b1; end
                end
            end
        end else if (m_mode == 2) begin
            if (!p && s) m_mode = 1;
        end
    endtask

    task automatic load_and_start(input logic [15:0] lv);
        clear = 1'b1; step(); clear = 1'b0;
        load = 1'b1; load_val = lv; step(); load = 1'b0;
        start = 1'b1; step(); start = 1'b0;
    endtask

    initial begin
        vecs[0] = '{16'hFFFF, 1'b0, 0,  16'h9599, 1'b0, 1'b0};
        vecs[1] = '{16'h1000, 1'b1, 4,  16'h0599, 1'b1, 1'b0};
        vecs[2] = '{16'h0100, 1'b1, 4,  16'h0099, 1'b1, 1'b0};
        vecs[3] = '{16'h0000, 1'b1, 3,  16'h0000, 1'b0, 1'b0};
        vecs[4] = '{16'h0012, 1'b1, 48, 16'h0000, 1'b0, 1'b1};
        vecs[5] = '{16'h0001, 1'b1, 3,  16'h0001, 1'b1, 1'b0};
        vecs[6] = '{16'h1A3C, 1'b0, 0,  16'h1539, 1'b0, 1'b0};
        vecs[7] = '{16'h0001, 1'b1, 4,  16'h0000, 1'b0, 1'b1};

        // Reset from a running state
        step(); step(); rst = 1'b0;
        load_and_start(16'h0305);
        repeat (5) step();
        rst = 1'b1; step(); step(); rst = 1'b0;
        chk("reset_val", 32'(dut_val), 32'h0);
        chk("reset_flags", 32'({running, done, expired}), 32'h0);
        $display("reset: val=%h running=%b done=%b expired=%b", dut_val, running, done, expired);

        for (int i = 0; i < 8; i++) begin
            clear = 1'b1; step(); clear = 1'b0;
            load = 1'b1; load_val = vecs[i].lv; step(); load = 1'b0;
            if (vecs[i].go) begin start = 1'b1; step(); start = 1'b0; end
            repeat (vecs[i].wait_n) step();
            chk($sformatf("vec%0d_val", i), 32'(dut_val), 32'(vecs[i].exp_val));
            chk($sformatf("vec%0d_run", i), 32'(running), 32'(vecs[i].exp_run));
            chk($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].exp_done));
            $display("vec%0d: load=%h start=%b wait=%0d -> val=%h running=%b done=%b",
                     i, vecs[i].lv, vecs[i].go, vecs[i].wait_n, dut_val, running, done);
        end

        // Basic expiry: value steps every TD cycles, expired pulses once at cycle 48
        load_and_start(16'h0012);
        for (int k = 1; k <= 48; k++) begin
            step();
            chk($sformatf("expiry_val_k%0d", k), 32'(dut_val), 32'(to_bcd(12 - k / TD)));
            chk($sformatf("expiry_pulse_k%0d", k), 32'(expired), 32'(k == 48));
        end
        chk("expiry_done", 32'(done), 32'h1);
        step();
        chk("expiry_pulse_gone", 32'({expired, done}), 32'b01);
        start = 1'b1; step(); start = 1'b0; step();
        chk("done_ignores_start", 32'({dut_val, running, done}), 32'({16'h0, 1'b0, 1'b1}));
        $display("expiry: val=%h done=%b expired=%b", dut_val, done, expired);

        // Pause keeps the prescaler phase
        load_and_start(16'h0005);
        repeat (6) step();
        pause = 1'b1;
        repeat (20) step();
        chk("pause_val", 32'(dut_val), 32'h0004);
        chk("pause_not_running", 32'(running), 32'h0);
        pause = 1'b0; start = 1'b1; step(); start = 1'b0;
        chk("resume_running", 32'(running), 32'h1);
        step();
        chk("resume_plus1", 32'(dut_val), 32'h0004);
        step();
        chk("resume_plus2", 32'(dut_val), 32'h0003);
        $display("pause: val=%h running=%b after resume", dut_val, running);

        // Load is ignored while running
        load_and_start(16'h0005);
        step();
        load = 1'b1; load_val = 16'h0200; step(); load = 1'b0;
        chk("load_in_run_val", 32'(dut_val), 32'h0005);
        chk("load_in_run_running", 32'(running), 32'h1);
        step(); step();
        chk("load_in_run_tick", 32'(dut_val), 32'h0004);
        $display("load_in_run: val=%h running=%b", dut_val, running);

        // clear beats start
        clear = 1'b1; start = 1'b1; step(); clear = 1'b0; start = 1'b0;
        chk("clear_start_val", 32'(dut_val), 32'h0);
        chk("clear_start_flags", 32'({running, done, expired}), 32'h0);
        $display("clear_start: val=%h running=%b", dut_val, running);

        // rst mid-run produces no expiry
        load_and_start(16'h0005);
        repeat (8) step();
        chk("pre_rst_val", 32'(dut_val), 32'h0003);
        rst = 1'b1; step(); rst = 1'b0;
        chk("rst_run_val", 32'(dut_val), 32'h0);
        chk("rst_run_flags", 32'({running, done, expired}), 32'h0);
        begin
            bit saw_exp;
            saw_exp = 1'b0;
            repeat (20) begin step(); saw_exp |= expired; end
            chk("rst_run_no_expiry", 32'({saw_exp, dut_val}), 32'h0);
        end
        $display("rst_mid_run: val=%h running=%b", dut_val, running);

        // Randomized run against the reference model
        rst = 1'b1; step(); rst = 1'b0;
        m_mode = 0; m_val = 0; m_pre = 0; m_exp = 1'b0;
        begin
            int bad;
            bad = errors;
            for (int n = 0; n < 3000; n++) begin
                rst   = ($urandom_range(0, 199) == 0);
                clear = ($urandom_range(0, 59) == 0);
                load  = ($urandom_range(0, 24) == 0);
                load_val = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 24));
                start = ($urandom_range(0, 3) == 0);
                pause = ($urandom_range(0, 9) == 0);
                model_step(rst, clear, load, load_val, start, pause);
                step();
                chk($sformatf("rand_cycle%0d", n), 32'({dut_val, running, done, expired}),
                    32'({to_bcd(m_val), m_mode == 1, m_mode == 3, m_exp}));
            end
            rst = 1'b0; clear = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
            $display("random: 3000 cycles, new errors=%0d", errors - bad);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ds_countdown.md
Name: ds_countdown

Overview:
- Loadable countdown timer with 0.1 s resolution. Counts a BCD value (M:SS.d, max 9:59.9) down to zero, then raises an expiry pulse.
- It is the down-counting counterpart of the team's up-counting decisecond counter and shares the same prescale convention: 10,000,000 cycles per decisecond at 100 MHz.
- Its digit outputs feed the seven-segment display path. Its expiry pulse feeds the alarm/LED logic.

Parameters:
- TICK_DIV, 10000000, clock cycles per decisecond tick (minimum 2; benches use 4).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- clear  in  1  abort and zero the timer
- load  in  1  capture load_val (one-cycle strobe)
- load_val  in  16  BCD {min[15:12], sec_t[11:8], sec_o[7:4], ds[3:0]}
- start  in  1  begin or resume counting (level sampled each cycle)
- pause  in  1  suspend counting (level sampled each cycle)
- min  out  4  minutes digit, 0-9
- sec_t  out  4  seconds tens digit, 0-5
- sec_o  out  4  seconds ones digit, 0-9
- ds  out  4  deciseconds digit, 0-9
- running  out  1  high in RUN
- done  out  1  high in DONE
- expired  out  1  one-cycle pulse on reaching zero

Behaviour:
- Reset (synchronous, rst high at a clk edge):
  - state=IDLE, all digits 0, prescaler 0, running=0, done=0, expired=0.
  - rst overrides all other inputs.
- States: IDLE, RUN, PAUSE, DONE. running=(state==RUN), done=(state==DONE).
- Input priority each cycle: rst > clear > load > pause > start.
- clear (any state): next state IDLE, digits 0, prescaler 0, no expired pulse.
- load:
  - Accepted in IDLE, PAUSE and DONE; ignored in RUN.
  - Digits register the clamped load_val: sec_t > 5 becomes 5; any other digit > 9 becomes 9.
  - Prescaler goes to 0 and next state is IDLE.
- IDLE + start:
  - If the value is nonzero: next state RUN, prescaler 0.
  - If the value is all zero: start is ignored and the block stays in IDLE.
- RUN:
  - Prescaler increments each cycle, 0..TICK_DIV-1.
  - When the prescaler equals TICK_DIV-1, a tick occurs: prescaler wraps to 0 and the value decrements by 0.1 s on the same edge.
  - The first decrement lands TICK_DIV cycles after the edge that entered RUN.
- Decrement (BCD borrow chain):
  - ds 0 becomes 9 and borrows from sec_o.
  - sec_o 0 becomes 9 and borrows from sec_t.
  - sec_t 0 becomes 5 and borrows from min.
  - Example: 1:00.0 becomes 0:59.9.
- Expiry:
  - A tick that makes the value 0:00.0 moves to DONE on the same edge.
  - expired=1 for exactly the cycle after that edge, coincident with done rising.
  - A value of zero is never decremented, so there is no wrap to 9:59.9.
- RUN + pause: next state PAUSE. The prescaler holds its value, and a tick does not fire on that edge.
- PAUSE + start (pause low): return to RUN. The prescaler resumes from its held value, so no fractional time is lost.
- start and pause high together: pause wins (RUN becomes PAUSE; PAUSE stays PAUSE).
- DONE:
  - Holds zero, done=1.
  - start is ignored; load or clear leaves DONE.
- In IDLE, PAUSE and DONE the prescaler does not advance.
- Widths: prescaler is $clog2(TICK_DIV) bits.
- All outputs are registered or decoded directly from registered state; there are no combinational paths from inputs to outputs.

Test Plan (TICK_DIV=4):
- Reset: assert rst for 2 cycles from arbitrary state -> digits 0000, IDLE, running=0, done=0, expired=0.
- Basic expiry: load 0x0012, start for 1 cycle ->
  - value steps 0012, 0011, 0010, 0009 ... 0001, 0000, every 4 cycles;
  - expired pulses once, 48 cycles after the start edge;
  - done=1 afterwards, and start in DONE has no effect.
- Borrow: load 0x1000, start -> after 4 cycles value=0599; with 0x0100 -> 0099.
- Pause preserves phase: start from 0x0005, pause 6 cycles after the start edge, hold 20 cycles, resume ->
  - value=0004 during the pause;
  - next decrement to 0003 exactly 2 cycles after the resume edge.
- Clamp and guards:
  - load 0xFFFF -> 9599;
  - load 0x0000 then start -> stays IDLE;
  - load 0x0200 while RUN -> ignored, countdown continues.
- Priority and reset mid-run:
  - clear and start together in RUN -> IDLE, 0000;
  - rst asserted in RUN at value 0003 -> next cycle 0000, IDLE, no expired pulse.
